// File: rtl/bptt_seq_ctrl_pkg.sv
// Shared LSTM sequencing definitions: controller state encoding and index width helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package bptt_seq_ctrl_pkg;

  // Sequencer phases, shared with the backprop controller so both agree on encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_BWD  = 2'd2
  } seq_state_e;

  // Width of a time-step index; never below one bit so degenerate sizes still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bptt_seq_ctrl.sv
// BPTT sequencer: drives NUM_ITERATIONS forward LSTM steps into a history register, then replays them newest-first.
// Latency: fwd_req one cycle after FWD entry/capture; BWD entered the cycle after the final capture; done one cycle after last handshake.
// Backpressure: forward side waits indefinitely for fwd_valid; backward side holds bwd_idx/bwd_data while bwd_ready is low.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, abort          begin a sequence (IDLE only), synchronous abandon
//   fwd_req, fwd_valid    step request pulse to the cell, cell answer
//   shift_en, step_idx    history capture strobe, current forward step
//   seq                   history register contents, slice k at [k*WIDTH +: WIDTH]
//   bwd_valid/ready/data/idx  backward replay stream
//   busy, done            not-idle flag, one-cycle completion pulse
module bptt_seq_ctrl
  import bptt_seq_ctrl_pkg::*;
#(
  parameter int NUM_ITERATIONS = 8,
  parameter int WIDTH          = 32,
  localparam int IW            = idx_width(NUM_ITERATIONS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  output logic                             fwd_req,
  input  logic                             fwd_valid,
  output logic                             shift_en,
  output logic [IW-1:0]                    step_idx,
  input  logic [NUM_ITERATIONS*WIDTH-1:0]  seq,
  output logic                             bwd_valid,
  input  logic                             bwd_ready,
  output logic signed [WIDTH-1:0]          bwd_data,
  output logic [IW-1:0]                    bwd_idx,
  output logic                             busy,
  output logic                             done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ITERATIONS - 1);

  seq_state_e    r_state;
  logic [IW-1:0] r_step;
  logic [IW-1:0] r_bidx;
  logic          r_req_out;  // a forward request is outstanding
  logic          r_fwd_req;
  logic          r_done;

  seq_state_e    w_state_nxt;
  logic [IW-1:0] w_step_nxt;
  logic [IW-1:0] w_bidx_nxt;
  logic          w_req_out_nxt;
  logic          w_fwd_req_nxt;
  logic          w_done_nxt;
  logic          w_capture;
  logic          w_bwd_hs;

  assign w_capture = (r_state == ST_FWD) && r_req_out && fwd_valid;
  assign w_bwd_hs  = (r_state == ST_BWD) && bwd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_bidx    <= '0;
      r_req_out <= 1'b0;
      r_fwd_req <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_bidx    <= w_bidx_nxt;
      r_req_out <= w_req_out_nxt;
      r_fwd_req <= w_fwd_req_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_bidx_nxt    = r_bidx;
    w_req_out_nxt = r_req_out;
    w_fwd_req_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // abort beats start when both arrive in IDLE
        if (start && !abort) begin
          w_state_nxt   = ST_FWD;
          w_step_nxt    = '0;
          w_req_out_nxt = 1'b1;
          w_fwd_req_nxt = 1'b1;
        end
      end
      ST_FWD: begin
        if (abort) begin
          // a coincident capture is strobed out but deliberately not counted
          w_state_nxt   = ST_IDLE;
          w_step_nxt    = '0;
          w_bidx_nxt    = '0;
          w_req_out_nxt = 1'b0;
        end else if (w_capture) begin
          w_req_out_nxt = 1'b0;
          if (r_step == LAST_IDX) begin
            // newest step sits in the top slice, so replay starts there
            w_state_nxt = ST_BWD;
            w_step_nxt  = '0;
            w_bidx_nxt  = LAST_IDX;
          end else begin
            w_step_nxt    = r_step + IW'(1);
            w_req_out_nxt = 1'b1;
            w_fwd_req_nxt = 1'b1;
          end
        end
      end
      ST_BWD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_step_nxt  = '0;
          w_bidx_nxt  = '0;
        end else if (w_bwd_hs) begin
          if (r_bidx == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_bidx_nxt = r_bidx - IW'(1);
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_step_nxt    = '0;
        w_bidx_nxt    = '0;
        w_req_out_nxt = 1'b0;
      end
    endcase
  end

  assign fwd_req   = r_fwd_req;
  assign shift_en  = w_capture;
  assign step_idx  = r_step;
  assign bwd_idx   = r_bidx;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign bwd_valid = (r_state == ST_BWD);
  assign bwd_data  = (r_state == ST_BWD) ? $signed(seq[int'(r_bidx)*WIDTH +: WIDTH]) : '0;

endmodule

// File: tb/tb_bptt_seq_ctrl.sv
// Testbench for bptt_seq_ctrl: randomized cell latency, backpressure, aborts and resets
// checked cycle by cycle against a count-based transaction model.
module tb_bptt_seq_ctrl;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int IW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 fwd_valid = 1'b0;
  logic                 bwd_ready = 1'b0;
  logic [N*W-1:0]       seq = '0;
  logic                 fwd_req, shift_en, bwd_valid, busy, done;
  logic [IW-1:0]        step_idx, bwd_idx;
  logic signed [W-1:0]  bwd_data;

  bptt_seq_ctrl #(.NUM_ITERATIONS(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fwd_req(fwd_req), .fwd_valid(fwd_valid), .shift_en(shift_en),
    .step_idx(step_idx), .seq(seq), .bwd_valid(bwd_valid),
    .bwd_ready(bwd_ready), .bwd_data(bwd_data), .bwd_idx(bwd_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: sequence progress as counts of captures and handshakes.
  bit          m_active = 0;
  int          m_caps = 0;
  int          m_acks = 0;
  bit          m_out = 0;
  bit          m_req_now = 0;
  bit          m_done_now = 0;
  logic [W-1:0] m_hist [N];

  // Stimulus policy.
  int  lat_min = 2, lat_max = 2;
  int  rdy_pct = 100;
  int  abort_pm = 0;
  bit  nominal = 1;
  bit  spur = 0;
  bit  abort_at4 = 0;
  bit  stall_armed = 0;
  int  stall_left = 0;
  int  cd = 0;
  logic [W-1:0] cell_data = '0;

  // External history shift register emulation.
  bit           sh_pend = 0;
  logic [W-1:0] sh_dat = '0;

  // Observations.
  int           n_req = 0, n_shift = 0, n_done = 0;
  logic [W-1:0] hs_q[$];

  task automatic clear_obs();
    n_req = 0; n_shift = 0; n_done = 0;
    hs_q.delete();
  endtask

  task automatic tick(input bit st);
    bit fwd_ph, bwd_ph, cap_exp, stalled, nreq, ndone;
    @(negedge clk);
    if (sh_pend) seq = {sh_dat, seq[N*W-1:W]};
    sh_pend = 0;
    fwd_ph = m_active && (m_caps < N);
    bwd_ph = m_active && (m_caps == N);

    start = st;
    fwd_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) fwd_valid = 1'b1;
    end else if (spur && !m_out && $urandom_range(0, 3) == 0) begin
      fwd_valid = 1'b1;
    end
    cell_data = nominal ? W'(100 + m_caps) : W'($urandom);
    stalled = 0;
    if (bwd_ph && (N - 1 - m_acks) == 5 && stall_armed) begin
      stall_armed = 0;
      stall_left = 3;
    end
    if (stall_left > 0) begin
      bwd_ready = 1'b0;
      stall_left--;
      stalled = 1;
    end else begin
      bwd_ready = ($urandom_range(1, 100) <= rdy_pct);
    end
    cap_exp = fwd_ph && m_out && fwd_valid;
    abort = (abort_at4 && cap_exp && m_caps == 3) || ($urandom_range(1, 1000) <= abort_pm);
    #1;

    chk_eq("busy", busy, m_active);
    chk_eq("fwd_req", fwd_req, m_req_now);
    chk_eq("shift_en", shift_en, cap_exp);
    chk_eq("done", done, m_done_now);
    chk_eq("bwd_valid", bwd_valid, bwd_ph);
    if (!bwd_ph) chk_eq("step_idx", step_idx, m_caps);
    if (bwd_ph) begin
      chk_eq("bwd_idx", bwd_idx, N - 1 - m_acks);
      chk_eq("bwd_data", {32'd0, $unsigned(bwd_data)}, {32'd0, m_hist[N-1-m_acks]});
    end else begin
      chk_eq("bwd_idx_idle", bwd_idx, 0);
      chk_eq("bwd_data_idle", {32'd0, $unsigned(bwd_data)}, 64'd0);
    end
    if (stalled && nominal) begin
      chk_eq("stall_idx", bwd_idx, 5);
      chk_eq("stall_data", {32'd0, $unsigned(bwd_data)}, 64'd105);
    end

    if (fwd_req) begin
      n_req++;
      cd = $urandom_range(lat_min, lat_max);
    end
    if (shift_en) begin
      n_shift++;
      sh_pend = 1;
      sh_dat = cell_data;
    end
    if (done) n_done++;

    nreq = 0; ndone = 0;
    if (!m_active) begin
      if (st && !abort) begin
        m_active = 1; m_caps = 0; m_acks = 0; m_out = 1; nreq = 1;
      end
    end else if (abort) begin
      m_active = 0; m_caps = 0; m_acks = 0; m_out = 0; cd = 0;
    end else if (m_caps < N) begin
      if (cap_exp) begin
        m_hist[m_caps] = cell_data;
        m_caps++;
        m_out = 0;
        if (m_caps < N) begin
          m_out = 1; nreq = 1;
        end
      end
    end else if (bwd_ready) begin
      hs_q.push_back(bwd_data);
      m_acks++;
      if (m_acks == N) begin
        m_active = 0; m_caps = 0; m_acks = 0; ndone = 1;
      end
    end
    m_req_now = nreq;
    m_done_now = ndone;
  endtask

  task automatic run_seq(input bit hold);
    int cyc;
    cyc = 0;
    tick(1'b1);
    while (m_active && cyc < 400) begin
      tick(hold);
      cyc++;
    end
    if (cyc >= 400) chk_eq("seq_timeout", 1, 0);
    tick(1'b0);
    tick(1'b0);
  endtask

  initial begin
    // Reset values while rst is low.
    #12;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_fwd_req", fwd_req, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_bwd_valid", bwd_valid, 0);
    chk_eq("rst_step_idx", step_idx, 0);
    chk_eq("rst_bwd_idx", bwd_idx, 0);
    @(negedge clk);
    rst = 1'b1;

    // Spurious fwd_valid in IDLE.
    spur = 1;
    repeat (6) tick(1'b0);
    spur = 0;

    // Nominal sequence: latency 2, ready always, slice k = k+100.
    clear_obs();
    run_seq(1'b0);
    chk_eq("nom_req_cnt", n_req, 8);
    chk_eq("nom_shift_cnt", n_shift, 8);
    chk_eq("nom_done_cnt", n_done, 1);
    chk_eq("nom_hs_cnt", hs_q.size(), 8);
    foreach (hs_q[i]) chk_eq("nom_hs_data", hs_q[i], 107 - i);

    // Backpressure at bwd_idx 5.
    clear_obs();
    stall_armed = 1;
    run_seq(1'b0);
    chk_eq("bp_hs_cnt", hs_q.size(), 8);
    foreach (hs_q[i]) chk_eq("bp_hs_data", hs_q[i], 107 - i);
    chk_eq("bp_done_cnt", n_done, 1);

    // Abort coincident with the 4th capture, then a clean restart.
    clear_obs();
    abort_at4 = 1;
    run_seq(1'b0);
    abort_at4 = 0;
    chk_eq("abort_done_cnt", n_done, 0);
    chk_eq("abort_shift_cnt", n_shift, 4);
    chk_eq("abort_idle", busy, 0);
    clear_obs();
    run_seq(1'b0);
    chk_eq("restart_shift_cnt", n_shift, 8);
    chk_eq("restart_done_cnt", n_done, 1);

    // start held high throughout FWD and BWD.
    clear_obs();
    run_seq(1'b1);
    chk_eq("hold_req_cnt", n_req, 8);
    chk_eq("hold_done_cnt", n_done, 1);

    // Randomized sequences: latency, ready, data, occasional aborts, spurious valids.
    nominal = 0; spur = 1; lat_min = 1; lat_max = 4; rdy_pct = 60; abort_pm = 15;
    for (int s = 0; s < 20; s++) run_seq(1'b0);
    abort_pm = 0;

    // Asynchronous reset mid-BWD at bwd_idx 3.
    nominal = 1; rdy_pct = 70;
    begin
      int cyc;
      cyc = 0;
      tick(1'b1);
      while (!(m_active && m_caps == N && (N - 1 - m_acks) == 3) && cyc < 400) begin
        tick(1'b0);
        cyc++;
      end
      if (cyc >= 400) chk_eq("reach_bidx3_timeout", 1, 0);
    end
    @(posedge clk);
    #2;
    chk_eq("pre_rst_bwd_idx", bwd_idx, 3);
    rst = 1'b0;
    #1;
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_fwd_req", fwd_req, 0);
    chk_eq("arst_done", done, 0);
    chk_eq("arst_bwd_valid", bwd_valid, 0);
    chk_eq("arst_bwd_idx", bwd_idx, 0);
    chk_eq("arst_step_idx", step_idx, 0);
    chk_eq("arst_bwd_data", {32'd0, $unsigned(bwd_data)}, 64'd0);
    m_active = 0; m_caps = 0; m_acks = 0; m_out = 0;
    m_req_now = 0; m_done_now = 0; cd = 0; sh_pend = 0;
    @(negedge clk);
    rst = 1'b1;
    clear_obs();
    nominal = 0; rdy_pct = 80;
    run_seq(1'b0);
    chk_eq("post_rst_done_cnt", n_done, 1);
    chk_eq("post_rst_shift_cnt", n_shift, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
